peg_l2_rx_frm_ctrl: RTL

Frame admission controller between the RMII RX reconciliation sublayer and the L2 RX packet buffer. Takes the 64b sop/eop/valid/error word stream from the RS, writes words into a circular packet RAM, and validates each frame for length, error and buffer space. It commits good frames by publishing a one-deep descriptor to the MAC RX consumer, and rolls back the write pointer for dropped frames.

---
 rtl/peg_l2_pkg.sv | 22 ++
 rtl/peg_l2_rx_desc_slot.sv | 46 ++++
 rtl/peg_l2_rx_frm_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/peg_l2_pkg.sv
// peg_l2_pkg: shared constants and types for the L2 RX frame path
package peg_l2_pkg;
  localparam int RX_DATA_W        = 64;
  localparam int RX_ADDR_W        = 11;
  localparam int RX_LEN_W         = 9;
  localparam int RX_MIN_FRM_WORDS = 8;
  localparam int RX_MAX_FRM_WORDS = 190;
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    NO_SPACE  = 3'd1,
    RUNT      = 3'd2,
    GIANT     = 3'd3,
    RX_ERR    = 3'd4,
    DESC_BUSY = 3'd5,
    TRUNC     = 3'd6
  } drop_reason_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DISCARD
  } rx_state_e;
endpackage

// File: rtl/peg_l2_rx_desc_slot.sv
// peg_l2_rx_desc_slot: one-deep valid/ready descriptor register, reloadable while draining
module peg_l2_rx_desc_slot
  import peg_l2_pkg::*;
#(
  parameter int AW = RX_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [AW-1:0]       ld_addr,
  input  logic [RX_LEN_W-1:0] ld_len,
  input  logic                ld_err,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [AW-1:0]       out_addr,
  output logic [RX_LEN_W-1:0] out_len,
  output logic                out_err
);
  logic                valid_q, valid_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [RX_LEN_W-1:0] len_q, len_d;
  logic                err_q, err_d;
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    addr_d  = load ? ld_addr : addr_q;
    len_d   = load ? ld_len : len_q;
    err_d   = load ? ld_err : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_len   = len_q;
  assign out_err   = err_q;
endmodule

// File: rtl/peg_l2_rx_frm_ctrl.sv
// peg_l2_rx_frm_ctrl: admits RS frames into the circular packet RAM, commits good ones, rolls back drops
module peg_l2_rx_frm_ctrl
  import peg_l2_pkg::*;
#(
  parameter int PKT_DATA_W    = RX_DATA_W,
  parameter int BUF_ADDR_W    = RX_ADDR_W,
  parameter int MIN_FRM_WORDS = RX_MIN_FRM_WORDS,
  parameter int MAX_FRM_WORDS = RX_MAX_FRM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic                  cfg_pass_bad,
  input  logic                  rs_valid,
  input  logic                  rs_sop,
  input  logic                  rs_eop,
  input  logic                  rs_error,
  input  logic [PKT_DATA_W-1:0] rs_data,
  input  logic [BUF_ADDR_W-1:0] buf_rd_ptr,
  output logic                  buf_wr_en,
  output logic [BUF_ADDR_W-1:0] buf_wr_addr,
  output logic [PKT_DATA_W-1:0] buf_wr_data,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [BUF_ADDR_W-1:0] desc_addr,
  output logic [8:0]            desc_len,
  output logic                  desc_err,
  output logic                  drop_pulse,
  output logic [2:0]            drop_reason
);
  localparam logic [BUF_ADDR_W-1:0] ONE       = BUF_ADDR_W'(1);
  localparam logic [BUF_ADDR_W-1:0] MAX_FREE  = BUF_ADDR_W'(MAX_FRM_WORDS);
  localparam logic [8:0]            GIANT_CNT = 9'(MAX_FRM_WORDS + 1);
  localparam logic [8:0]            MIN_CNT   = 9'(MIN_FRM_WORDS);
  rx_state_e             state_q, state_d;
  logic [BUF_ADDR_W-1:0] commit_q, commit_d, wr_ptr_q, wr_ptr_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PKT_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  drop_q, drop_d;
  drop_reason_e          reason_q, reason_d;
  logic [BUF_ADDR_W-1:0] free, beat_addr;
  logic [8:0]            beat_cnt;
  logic                  beat_err, start, frame_beat, slot_busy, load;
  always_comb begin
    state_d    = state_q;
    commit_d   = commit_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    drop_d     = 1'b0;
    reason_d   = NONE;
    load       = 1'b0;
    free       = buf_rd_ptr - commit_q - ONE;
    slot_busy  = desc_valid & ~desc_ready;
    start      = rs_valid & rs_sop & cfg_en & (state_q != ST_DISCARD);
    frame_beat = start | (rs_valid & ~rs_sop & (state_q == ST_RECV));
    beat_addr  = start ? commit_q : wr_ptr_q;
    beat_cnt   = start ? 9'd1 : (cnt_q == 9'h1ff ? cnt_q : cnt_q + 9'd1);
    beat_err   = rs_error | (~start & err_q);
    // a sop inside a frame truncates it; the new sop is then handled as if seen in IDLE
    if (rs_valid & rs_sop & (state_q == ST_RECV)) begin
      drop_d   = 1'b1;
      reason_d = TRUNC;
      wr_ptr_d = commit_q;
      state_d  = ST_IDLE;
    end
    if (rs_valid & rs_eop & (state_q == ST_DISCARD))
      state_d = ST_IDLE;
    if (start & (free < MAX_FREE)) begin
      drop_d = 1'b1;
      if (state_q == ST_IDLE)
        reason_d = NO_SPACE;
      state_d = rs_eop ? ST_IDLE : ST_DISCARD;
    end else if (frame_beat) begin
      if (beat_cnt == GIANT_CNT) begin
        drop_d   = 1'b1;
        reason_d = GIANT;
        wr_ptr_d = commit_q;
        state_d  = rs_eop ? ST_IDLE : ST_DISCARD;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = beat_addr;
        wr_data_d = rs_data;
        wr_ptr_d  = beat_addr + ONE;
        cnt_d     = beat_cnt;
        err_d     = beat_err;
        state_d   = ST_RECV;
        if (rs_eop) begin
          state_d  = ST_IDLE;
          wr_ptr_d = commit_q;
          drop_d   = 1'b1;
          if (beat_err & ~cfg_pass_bad)
            reason_d = RX_ERR;
          else if (beat_cnt < MIN_CNT)
            reason_d = RUNT;
          else if (slot_busy)
            reason_d = DESC_BUSY;
          else begin
            drop_d   = 1'b0;
            load     = 1'b1;
            commit_d = beat_addr + ONE;
            wr_ptr_d = beat_addr + ONE;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      commit_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
      reason_q  <= NONE;
    end else begin
      state_q   <= state_d;
      commit_q  <= commit_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
      reason_q  <= reason_d;
    end
  end
  peg_l2_rx_desc_slot #(.AW(BUF_ADDR_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .ld_addr   (commit_q),
    .ld_len    (beat_cnt),
    .ld_err    (beat_err),
    .out_ready (desc_ready),
    .out_valid (desc_valid),
    .out_addr  (desc_addr),
    .out_len   (desc_len),
    .out_err   (desc_err)
  );
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign drop_pulse  = drop_q;
  assign drop_reason = reason_q;
endmodule
